// File: rtl/bmp_header_parser_pkg.sv
// Shared constants, enums and helpers for the BMP header parser.
// Byte offsets index the first HDR_BYTES bytes of a little-endian BMP file.
package bmp_pkg;

    localparam int unsigned MAGIC     = 0;
    localparam int unsigned FSIZE     = 2;
    localparam int unsigned OFFBITS   = 10;
    localparam int unsigned WIDTH     = 18;
    localparam int unsigned HEIGHT    = 22;
    localparam int unsigned PLANES    = 26;
    localparam int unsigned BPP       = 28;
    localparam int unsigned COMPR     = 30;
    localparam int unsigned HDR_BYTES = 34;

    typedef enum logic [2:0] {
        ERR_OK         = 3'd0,
        ERR_BAD_MAGIC  = 3'd1,
        ERR_BAD_PLANES = 3'd2,
        ERR_BAD_BPP    = 3'd3,
        ERR_COMPRESSED = 3'd4,
        ERR_TOO_BIG    = 3'd5,
        ERR_BAD_OFFSET = 3'd6
    } err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] le32(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/bmp_header_parser_if.sv
// Byte-wide read port between the header parser and the image memory.
interface bmp_header_parser_if #(
    parameter int ADDR_W = 15
) ();
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    modport master (output mem_rd, output mem_addr, input mem_rdata);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/bmp_header_parser_stride_calc.sv
// Padded BMP row stride: bytes per row rounded up to a 4-byte boundary.
// bpp is one of 1/8/24, so the width product reduces to shifts and one add.
module bmp_stride_calc #(
    parameter int ADDR_W = 15,
    parameter int DIM_W  = 12
) (
    input  logic [DIM_W-1:0]  width,
    input  logic [4:0]        bpp,
    output logic [ADDR_W-1:0] stride
);
    localparam int P_W = DIM_W + 6;

    logic [P_W-1:0] w_ext;
    logic [P_W-1:0] bits;
    logic [P_W-1:0] rounded;
    logic [P_W-1:0] bytes_padded;

    always_comb begin
        w_ext = P_W'(width);
        case (bpp)
            5'd1:    bits = w_ext;
            5'd8:    bits = w_ext << 3;
            5'd24:   bits = (w_ext << 4) + (w_ext << 3);
            default: bits = '0;
        endcase
        rounded      = bits + P_W'(31);
        bytes_padded = (rounded >> 5) << 2;
        stride       = ADDR_W'(bytes_padded);
    end
endmodule

// File: rtl/bmp_header_parser.sv
// Reads the 34-byte BMP header, validates it and publishes an image descriptor.
// Latency from start to done is a fixed 37 cycles regardless of the outcome.
module bmp_header_parser
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DIM_W  = 12
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                start,
    bmp_header_parser_if.master mem,
    output logic                done,
    output logic [2:0]          err,
    output logic [ADDR_W-1:0]   pix_offset,
    output logic [DIM_W-1:0]    img_width,
    output logic [DIM_W-1:0]    img_height,
    output logic                top_down,
    output logic [4:0]          bpp,
    output logic [ADDR_W-1:0]   row_stride
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(HDR_BYTES - 1);

    state_t            state, state_nxt;
    logic              rd_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        hdr [HDR_BYTES];

    logic [31:0] fsize_f, off_f, width_f, height_f, compr_f, hmag;
    logic [15:0] planes_f, bpp_f;
    logic        too_big;
    err_t        err_nxt;
    logic [ADDR_W-1:0] stride;

    bmp_stride_calc #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_stride (
        .width  (width_f[DIM_W-1:0]),
        .bpp    (bpp_f[4:0]),
        .stride (stride)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = READ;
            READ:       if (rd_d && addr_d == LAST_ADDR) state_nxt = CHECK;
            CHECK:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fsize_f  = le32(hdr[FSIZE], hdr[FSIZE+1], hdr[FSIZE+2], hdr[FSIZE+3]);
        off_f    = le32(hdr[OFFBITS], hdr[OFFBITS+1], hdr[OFFBITS+2], hdr[OFFBITS+3]);
        width_f  = le32(hdr[WIDTH], hdr[WIDTH+1], hdr[WIDTH+2], hdr[WIDTH+3]);
        height_f = le32(hdr[HEIGHT], hdr[HEIGHT+1], hdr[HEIGHT+2], hdr[HEIGHT+3]);
        compr_f  = le32(hdr[COMPR], hdr[COMPR+1], hdr[COMPR+2], hdr[COMPR+3]);
        planes_f = {hdr[PLANES+1], hdr[PLANES]};
        bpp_f    = {hdr[BPP+1], hdr[BPP]};
        hmag     = height_f[31] ? (~height_f + 32'd1) : height_f;
        // Negative width is rejected outright, so only its positive range needs bounding.
        too_big  = $signed(width_f) <= 0 || width_f[31:DIM_W] != '0 ||
                   hmag[31:DIM_W] != '0 || height_f == '0;

        err_nxt = ERR_OK;
        if (hdr[MAGIC] != 8'h42 || hdr[MAGIC+1] != 8'h4D)      err_nxt = ERR_BAD_MAGIC;
        else if (planes_f != 16'd1)                            err_nxt = ERR_BAD_PLANES;
        else if (bpp_f != 16'd1 && bpp_f != 16'd8 && bpp_f != 16'd24) err_nxt = ERR_BAD_BPP;
        else if (compr_f != '0)                                err_nxt = ERR_COMPRESSED;
        else if (too_big)                                      err_nxt = ERR_TOO_BIG;
        else if (off_f < 32'(HDR_BYTES) || off_f >= fsize_f)   err_nxt = ERR_BAD_OFFSET;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rd_d && addr_d < ADDR_W'(HDR_BYTES)) hdr[addr_d[5:0]] <= mem.mem_rdata;
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state        <= IDLE;
            mem.mem_rd   <= 1'b0;
            mem.mem_addr <= '0;
            rd_d         <= 1'b0;
            addr_d       <= '0;
            err          <= '0;
            pix_offset   <= '0;
            img_width    <= '0;
            img_height   <= '0;
            top_down     <= 1'b0;
            bpp          <= '0;
            row_stride   <= '0;
        end else begin
            state  <= state_nxt;
            rd_d   <= mem.mem_rd;
            addr_d <= mem.mem_addr;
            if ((state == IDLE || state == DONE) && start) begin
                mem.mem_rd   <= 1'b1;
                mem.mem_addr <= '0;
            end else if (mem.mem_rd) begin
                if (mem.mem_addr == LAST_ADDR) mem.mem_rd <= 1'b0;
                else                           mem.mem_addr <= mem.mem_addr + ADDR_W'(1);
            end
            if (state == CHECK) begin
                err        <= err_nxt;
                pix_offset <= off_f[ADDR_W-1:0];
                img_width  <= width_f[DIM_W-1:0];
                img_height <= hmag[DIM_W-1:0];
                top_down   <= height_f[31];
                bpp        <= bpp_f[4:0];
                row_stride <= stride;
            end
        end
    end

    assign done = (state == DONE);
endmodule
